// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arm_pkg
//  Description : Shared definitions for the ARM-subset pipeline: execute
//                command encodings, shifter type codes and status-register
//                bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package arm_pkg;

    // Execute-stage ALU commands. CMP/TST arrive as SUB/AND with write-back
    // disabled; LDR/STR arrive as ADD (address = Rn + offset).
    typedef enum logic [3:0] {
        EXE_MOV = 4'b0001,
        EXE_MVN = 4'b1001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000
    } exe_cmd_e;

    // Shifter type field, shift_operand[6:5]
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Bit positions inside the 4-bit {N,Z,C,V} status word
    localparam int ST_N = 3;
    localparam int ST_Z = 2;
    localparam int ST_C = 1;
    localparam int ST_V = 0;

endpackage : arm_pkg
`default_nettype wire

// File: rtl/val2_gen.sv
`default_nettype none
// ============================================================================
//  Module      : val2_gen
//  Description : Combinational second-operand (Val2) generator.
//                  imm_i=1          : 8-bit immediate rotated right by 2*rot
//                  mem_en_i=1       : zero-extended 12-bit memory offset
//                  otherwise        : val_rm_i shifted by an immediate amount
//  Ports       : imm_i           - I bit
//                mem_en_i        - load or store in flight
//                val_rm_i        - Rm register value
//                shift_operand_i - 12-bit operand-2 field
//                val2_o          - generated operand
//  Revision    : 1.0 - initial release
// ============================================================================
module val2_gen
    import arm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            imm_i,
    input  logic            mem_en_i,
    input  logic [XLEN-1:0] val_rm_i,
    input  logic [11:0]     shift_operand_i,
    output logic [XLEN-1:0] val2_o
);

    logic [XLEN-1:0]   w_imm_ext;
    logic [4:0]        w_imm_rot;
    logic [2*XLEN-1:0] w_imm_dbl;
    logic [4:0]        w_sh_amt;
    logic [2*XLEN-1:0] w_rm_dbl;
    logic [XLEN-1:0]   w_shifted;

    // Rotates are done by shifting a doubled copy right, so a rotate of 0
    // needs no special case.
    assign w_imm_ext = {{(XLEN-8){1'b0}}, shift_operand_i[7:0]};
    assign w_imm_rot = {shift_operand_i[11:8], 1'b0};
    assign w_imm_dbl = {w_imm_ext, w_imm_ext} >> w_imm_rot;

    assign w_sh_amt  = shift_operand_i[11:7];
    assign w_rm_dbl  = {val_rm_i, val_rm_i} >> w_sh_amt;

    always_comb begin
        w_shifted = val_rm_i;
        case (shift_operand_i[6:5])
            SH_LSL:  w_shifted = val_rm_i << w_sh_amt;
            SH_LSR:  w_shifted = val_rm_i >> w_sh_amt;
            SH_ASR:  w_shifted = $unsigned($signed(val_rm_i) >>> w_sh_amt);
            SH_ROR:  w_shifted = w_rm_dbl[XLEN-1:0];
            default: w_shifted = val_rm_i;
        endcase
    end

    always_comb begin
        if (imm_i) begin
            val2_o = w_imm_dbl[XLEN-1:0];
        end else if (mem_en_i) begin
            val2_o = {{(XLEN-12){1'b0}}, shift_operand_i};
        end else begin
            val2_o = w_shifted;
        end
    end

endmodule : val2_gen
`default_nettype wire

// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : exe_stage
//  Description : Execute stage of the 5-stage ARM-subset pipeline. Builds
//                Val2, runs the ALU, owns the NZCV status register, resolves
//                the branch target and registers results into EXE/MEM.
//  Ports       : clk, rst            - clock, async active-high reset
//                mem_stall           - hold EXE/MEM register and status
//                *_in, val_*, imm,
//                shift_operand,
//                signed_imm_24       - registered ID-stage outputs
//                branch_taken/addr   - combinational branch resolve to IF
//                status              - registered {N,Z,C,V}
//                *_out, alu_res      - EXE/MEM pipeline register
//  Revision    : 1.0 - initial release
// ============================================================================
module exe_stage
    import arm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_stall,
    input  logic            wb_en_in,
    input  logic            mem_r_in,
    input  logic            mem_w_in,
    input  logic            b_in,
    input  logic            s_in,
    input  logic [3:0]      exe_cmd,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] val_rn,
    input  logic [XLEN-1:0] val_rm,
    input  logic            imm,
    input  logic [11:0]     shift_operand,
    input  logic [23:0]     signed_imm_24,
    input  logic [RA_W-1:0] dest_in,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_addr,
    output logic [3:0]      status,
    output logic            wb_en_out,
    output logic            mem_r_out,
    output logic            mem_w_out,
    output logic [XLEN-1:0] alu_res,
    output logic [XLEN-1:0] val_rm_out,
    output logic [RA_W-1:0] dest_out,
    output logic [XLEN-1:0] pc_out
);

    logic [XLEN-1:0] w_val2;
    logic [XLEN-1:0] w_alu_b;
    logic            w_cin;
    logic            w_arith;
    logic            w_flags_ok;
    logic [XLEN:0]   w_sum;
    logic [XLEN-1:0] w_res;
    logic [3:0]      w_flags;

    logic [3:0]      status_q,  status_d;
    logic            wb_en_q,   mem_r_q,  mem_w_q;
    logic [XLEN-1:0] alu_res_q, val_rm_q, pc_q;
    logic [RA_W-1:0] dest_q;

    val2_gen #(
        .XLEN (XLEN)
    ) u_val2_gen (
        .imm_i           (imm),
        .mem_en_i        (mem_r_in | mem_w_in),
        .val_rm_i        (val_rm),
        .shift_operand_i (shift_operand),
        .val2_o          (w_val2)
    );

    // ------------------------------------------------------------------
    // ALU: all arithmetic goes through one adder; subtraction feeds ~Val2
    // with the appropriate carry-in.
    // ------------------------------------------------------------------
    always_comb begin
        w_alu_b    = w_val2;
        w_cin      = 1'b0;
        w_arith    = 1'b0;
        w_flags_ok = 1'b1;
        case (exe_cmd)
            EXE_ADD: w_arith = 1'b1;
            EXE_ADC: begin w_arith = 1'b1; w_cin = status_q[ST_C]; end
            EXE_SUB: begin w_arith = 1'b1; w_alu_b = ~w_val2; w_cin = 1'b1; end
            EXE_SBC: begin w_arith = 1'b1; w_alu_b = ~w_val2; w_cin = status_q[ST_C]; end
            EXE_MOV, EXE_MVN, EXE_AND, EXE_ORR, EXE_EOR: w_flags_ok = 1'b1;
            default: w_flags_ok = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, val_rn} + {1'b0, w_alu_b} + {{XLEN{1'b0}}, w_cin};

    always_comb begin
        w_res = '0;
        case (exe_cmd)
            EXE_MOV: w_res = w_val2;
            EXE_MVN: w_res = ~w_val2;
            EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC: w_res = w_sum[XLEN-1:0];
            EXE_AND: w_res = val_rn & w_val2;
            EXE_ORR: w_res = val_rn | w_val2;
            EXE_EOR: w_res = val_rn ^ w_val2;
            default: w_res = '0;
        endcase
    end

    // Logic/move ops keep C and V; unknown commands keep everything.
    always_comb begin
        w_flags = status_q;
        if (w_flags_ok) begin
            w_flags[ST_N] = w_res[XLEN-1];
            w_flags[ST_Z] = (w_res == '0);
            if (w_arith) begin
                w_flags[ST_C] = w_sum[XLEN];
                w_flags[ST_V] = (val_rn[XLEN-1] == w_alu_b[XLEN-1]) &&
                                (w_res[XLEN-1] != val_rn[XLEN-1]);
            end
        end
    end

    assign status_d = (s_in && !mem_stall) ? w_flags : status_q;

    // ------------------------------------------------------------------
    // Branch resolve (zero latency)
    // ------------------------------------------------------------------
    assign branch_taken = b_in;
    assign branch_addr  = pc_in + {{(XLEN-26){signed_imm_24[23]}}, signed_imm_24, 2'b00};

    // ------------------------------------------------------------------
    // Status and EXE/MEM registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q  <= '0;
            wb_en_q   <= 1'b0;
            mem_r_q   <= 1'b0;
            mem_w_q   <= 1'b0;
            alu_res_q <= '0;
            val_rm_q  <= '0;
            dest_q    <= '0;
            pc_q      <= '0;
        end else begin
            status_q <= status_d;
            if (!mem_stall) begin
                wb_en_q   <= wb_en_in;
                mem_r_q   <= mem_r_in;
                mem_w_q   <= mem_w_in;
                alu_res_q <= w_res;
                val_rm_q  <= val_rm;
                dest_q    <= dest_in;
                pc_q      <= pc_in;
            end
        end
    end

    assign status     = status_q;
    assign wb_en_out  = wb_en_q;
    assign mem_r_out  = mem_r_q;
    assign mem_w_out  = mem_w_q;
    assign alu_res    = alu_res_q;
    assign val_rm_out = val_rm_q;
    assign dest_out   = dest_q;
    assign pc_out     = pc_q;

endmodule : exe_stage
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exe_stage
//  Description : Self-checking bench for exe_stage. A behavioural model
//                predicts the EXE/MEM register contents for every issued
//                instruction; predictions are queued and compared one cycle
//                later when the stage presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_stall = 1'b0;
    logic        wb_en_in = 1'b0, mem_r_in = 1'b0, mem_w_in = 1'b0;
    logic        b_in = 1'b0, s_in = 1'b0, imm = 1'b0;
    logic [3:0]  exe_cmd = '0;
    logic [31:0] pc_in = '0, val_rn = '0, val_rm = '0;
    logic [11:0] shift_operand = '0;
    logic [23:0] signed_imm_24 = '0;
    logic [3:0]  dest_in = '0;

    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [3:0]  status;
    logic        wb_en_out, mem_r_out, mem_w_out;
    logic [31:0] alu_res, val_rm_out, pc_out;
    logic [3:0]  dest_out;

    exe_stage #(.XLEN(32), .RA_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_stall     (mem_stall),
        .wb_en_in      (wb_en_in),
        .mem_r_in      (mem_r_in),
        .mem_w_in      (mem_w_in),
        .b_in          (b_in),
        .s_in          (s_in),
        .exe_cmd       (exe_cmd),
        .pc_in         (pc_in),
        .val_rn        (val_rn),
        .val_rm        (val_rm),
        .imm           (imm),
        .shift_operand (shift_operand),
        .signed_imm_24 (signed_imm_24),
        .dest_in       (dest_in),
        .branch_taken  (branch_taken),
        .branch_addr   (branch_addr),
        .status        (status),
        .wb_en_out     (wb_en_out),
        .mem_r_out     (mem_r_out),
        .mem_w_out     (mem_w_out),
        .alu_res       (alu_res),
        .val_rm_out    (val_rm_out),
        .dest_out      (dest_out),
        .pc_out        (pc_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        wb, mr, mw;
        logic [31:0] res, rm, pc;
        logic [3:0]  dest, st;
    } exp_t;

    exp_t q_exp[$];
    exp_t m_cur;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_val2();
        logic [31:0] v;
        int          amt;
        if (imm) begin
            v = {24'h0, shift_operand[7:0]};
            for (int k = 0; k < 2 * int'(shift_operand[11:8]); k++) v = {v[0], v[31:1]};
        end else if (mem_r_in || mem_w_in) begin
            v = {20'h0, shift_operand};
        end else begin
            v   = val_rm;
            amt = int'(shift_operand[11:7]);
            for (int k = 0; k < amt; k++) begin
                case (shift_operand[6:5])
                    2'd0:    v = {v[30:0], 1'b0};
                    2'd1:    v = {1'b0, v[31:1]};
                    2'd2:    v = {v[31], v[31:1]};
                    default: v = {v[0], v[31:1]};
                endcase
            end
        end
        return v;
    endfunction

    function automatic exp_t m_next(input exp_t cur);
        exp_t        e;
        logic [31:0] v2, r;
        logic [3:0]  f;
        longint      ua, sa;
        logic        c;
        bit          upd, ar;
        e   = cur;
        v2  = m_val2();
        c   = cur.st[1];
        f   = cur.st;
        upd = 1'b1;
        ar  = 1'b0;
        ua  = 0;
        sa  = 0;
        r   = '0;
        case (exe_cmd)
            4'd1: r = v2;
            4'd9: r = ~v2;
            4'd2, 4'd3: begin
                ar = 1'b1;
                ua = longint'({32'h0, val_rn}) + longint'({32'h0, v2}) + ((exe_cmd == 4'd3) ? longint'(c) : 0);
                sa = longint'($signed(val_rn)) + longint'($signed(v2)) + ((exe_cmd == 4'd3) ? longint'(c) : 0);
            end
            4'd4, 4'd5: begin
                ar = 1'b1;
                ua = longint'({32'h0, val_rn}) + longint'({32'h0, ~v2}) + ((exe_cmd == 4'd4) ? 1 : longint'(c));
                sa = longint'($signed(val_rn)) + longint'($signed(~v2)) + ((exe_cmd == 4'd4) ? 1 : longint'(c));
            end
            4'd6: r = val_rn & v2;
            4'd7: r = val_rn | v2;
            4'd8: r = val_rn ^ v2;
            default: upd = 1'b0;
        endcase
        if (ar) r = ua[31:0];
        if (upd) begin
            f[3] = r[31];
            f[2] = (r == 32'h0);
            if (ar) begin
                f[1] = ua[32];
                f[0] = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
            end
        end
        if (!mem_stall) begin
            e.wb   = wb_en_in;
            e.mr   = mem_r_in;
            e.mw   = mem_w_in;
            e.res  = r;
            e.rm   = val_rm;
            e.pc   = pc_in;
            e.dest = dest_in;
            if (s_in) e.st = f;
        end
        return e;
    endfunction

    // Drive inputs are already set (just after a negedge). Check the branch
    // resolve, queue the prediction, then compare on the next negedge.
    task automatic issue();
        exp_t        e;
        logic [31:0] off;
        #1;
        off = {{8{signed_imm_24[23]}}, signed_imm_24};
        check("br_taken", {63'h0, branch_taken}, {63'h0, b_in});
        check("br_addr", {32'h0, branch_addr}, {32'h0, pc_in + off * 32'd4});
        e = m_next(m_cur);
        q_exp.push_back(e);
        m_cur = e;
        @(negedge clk);
        if (q_exp.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = q_exp.pop_front();
            check("wb_en",  {63'h0, wb_en_out}, {63'h0, e.wb});
            check("mem_r",  {63'h0, mem_r_out}, {63'h0, e.mr});
            check("mem_w",  {63'h0, mem_w_out}, {63'h0, e.mw});
            check("alu_res", {32'h0, alu_res},  {32'h0, e.res});
            check("val_rm_out", {32'h0, val_rm_out}, {32'h0, e.rm});
            check("pc_out", {32'h0, pc_out},    {32'h0, e.pc});
            check("dest",   {60'h0, dest_out},  {60'h0, e.dest});
            check("status", {60'h0, status},    {60'h0, e.st});
        end
    endtask

    task automatic set_ins(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                           input logic im, input logic [11:0] so, input logic s,
                           input logic wb, input logic mr, input logic mw, input logic stall);
        exe_cmd = cmd; val_rn = rn; val_rm = rm; imm = im; shift_operand = so;
        s_in = s; wb_en_in = wb; mem_r_in = mr; mem_w_in = mw; mem_stall = stall;
        b_in = 1'b0; signed_imm_24 = 24'h0;
        pc_in = pc_in + 32'd4;
        dest_in = dest_in + 4'd1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_status"}, {60'h0, status}, 64'h0);
        check({tag, "_ctl"}, {61'h0, wb_en_out, mem_r_out, mem_w_out}, 64'h0);
        check({tag, "_res"}, {32'h0, alu_res}, 64'h0);
        check({tag, "_rm"},  {32'h0, val_rm_out}, 64'h0);
        check({tag, "_pc"},  {32'h0, pc_out}, 64'h0);
        check({tag, "_dest"}, {60'h0, dest_out}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        m_cur = '{default: '0};
        #1 rst = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // ADD with rotated immediate: 0xFF ror 8 = 0xFF000000, +1
        set_ins(4'd2, 32'h1, 32'h0, 1'b1, 12'h4FF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        issue();
        check("tp_imm_res", {32'h0, alu_res}, 64'hFF000001);
        check("tp_imm_st", {60'h0, status}, 64'b1000);

        // SUB 5-5 -> Z and C
        set_ins(4'd4, 32'd5, 32'd5, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        issue();
        check("tp_sub_st", {60'h0, status}, 64'b0110);

        // Signed overflow, then MOV keeps C/V
        set_ins(4'd2, 32'h7FFFFFFF, 32'h1, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        issue();
        check("tp_ovf_res", {32'h0, alu_res}, 64'h80000000);
        check("tp_ovf_st", {60'h0, status}, 64'b1001);
        set_ins(4'd1, 32'h0, 32'h0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        issue();
        check("tp_mov_st", {60'h0, status}, 64'b0101);

        // Branch resolves in the same cycle
        set_ins(4'd0, 32'h0, 32'h0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        b_in = 1'b1; pc_in = 32'h100; signed_imm_24 = 24'hFFFFFE;
        #1;
        check("tp_br_taken", {63'h0, branch_taken}, 64'h1);
        check("tp_br_addr", {32'h0, branch_addr}, 64'hF8);
        issue();

        // Bubble: all-zero controls, status held
        set_ins(4'd0, 32'h0, 32'h0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue();
        check("bubble_st", {60'h0, status}, 64'b0101);

        // Load address: 0x400 + zero-extended 0xFFC, then 3 stall cycles
        set_ins(4'd2, 32'h400, 32'hDEAD, 1'b0, 12'hFFC, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        issue();
        check("tp_ldr_res", {32'h0, alu_res}, 64'h13FC);
        for (int i = 0; i < 3; i++) begin
            set_ins(4'd4, 32'h9 + i, 32'h3, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
            issue();
            check("stall_res", {32'h0, alu_res}, 64'h13FC);
            check("stall_mr", {63'h0, mem_r_out}, 64'h1);
        end
        set_ins(4'd7, 32'hF0, 32'h0F, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        issue();
        check("release_res", {32'h0, alu_res}, 64'hFF);

        // Randomised mix: every command, shift type, stall and branch
        for (int i = 0; i < 60; i++) begin
            set_ins(4'($urandom_range(0, 10)), $urandom, $urandom, 1'($urandom_range(0, 2) == 0),
                    12'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 4) == 0),
                    1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 4) == 0));
            b_in = 1'($urandom);
            signed_imm_24 = 24'($urandom);
            issue();
        end

        // Async reset between edges
        set_ins(4'd3, 32'h12345678, 32'h1, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_all_zero("midrst");
        q_exp.delete();
        m_cur = '{default: '0};
        @(negedge clk);
        rst = 1'b0;
        set_ins(4'd8, 32'hA5A5A5A5, 32'hFFFF0000, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        issue();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_exe_stage
`default_nettype wire
